// File: rtl/mc14500b_uart_loader.sv
`default_nettype none
// ============================================================================
//  Module   : mc14500b_uart_loader
//  Function : UART (8N1) program loader for the MC14500B demo. It writes a
//             framed image into instruction RAM and holds the CPU in reset
//             while the load is in progress.
//  Revision : 1.0 - initial release
// ============================================================================
module mc14500b_uart_loader #(
  parameter int CLKS_PER_BIT   = 104,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter bit BOOT_RUN       = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX,
  output logic                  MEM_WE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [7:0]            MEM_DATA,
  output logic                  CPU_RST,
  output logic                  BUSY,
  output logic                  LOAD_OK,
  output logic                  LOAD_ERR
);

  localparam int                c_CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int                c_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_FULL_M1 = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_TO_W-1:0]  c_TO_M1   = c_TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_TO_W-1:0]  c_TO_ONE  = c_TO_W'(1);
  localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE = ADDR_WIDTH'(1);
  localparam int                c_MAX_LEN = 1 << ADDR_WIDTH;
  localparam logic [7:0]        c_SYNC    = 8'hA5;

  // RX synchroniser; r_rx_prev gives the falling-edge reference
  logic r_rx_meta, r_rx_sync, r_rx_prev;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t            r_rx_state, w_rx_state_nxt;
  logic [c_CNT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
  logic [2:0]           r_bit_idx, w_bit_idx_nxt;
  logic [7:0]           r_shift, w_shift_nxt;
  logic                 w_rx_valid, w_rx_ferr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rx_state <= RX_IDLE;
      r_bit_cnt  <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shift    <= w_shift_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_shift_nxt    = r_shift;
    w_rx_valid     = 1'b0;
    w_rx_ferr      = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (r_rx_prev && !r_rx_sync) begin
          w_rx_state_nxt = RX_START;
          w_bit_cnt_nxt  = '0;
        end
      end
      RX_START: begin
        if (r_bit_cnt == c_HALF_M1) begin
          w_bit_cnt_nxt  = '0;
          w_bit_idx_nxt  = '0;
          w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + c_CNT_ONE;
        end
      end
      RX_DATA: begin
        if (r_bit_cnt == c_FULL_M1) begin
          w_bit_cnt_nxt = '0;
          w_shift_nxt   = {r_rx_sync, r_shift[7:1]};
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
            w_rx_state_nxt = RX_STOP;
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + c_CNT_ONE;
        end
      end
      RX_STOP: begin
        if (r_bit_cnt == c_FULL_M1) begin
          w_bit_cnt_nxt  = '0;
          w_rx_state_nxt = RX_IDLE;
          w_rx_valid     = r_rx_sync;
          w_rx_ferr      = !r_rx_sync;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + c_CNT_ONE;
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  typedef enum logic [1:0] {ST_HUNT, ST_LEN, ST_DATA, ST_SUM} ld_state_t;

  ld_state_t             r_state, w_state_nxt;
  logic [8:0]            r_remaining, w_remaining_nxt;
  logic [7:0]            r_sum, w_sum_nxt;
  logic [ADDR_WIDTH-1:0] r_ptr, w_ptr_nxt;
  logic [c_TO_W-1:0]     r_to_cnt, w_to_cnt_nxt;
  logic                  r_mem_we, w_mem_we_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [7:0]            r_mem_data, w_mem_data_nxt;
  logic                  r_cpu_rst, w_cpu_rst_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_ok, w_ok_nxt;
  logic                  r_err, w_err_nxt;
  logic                  r_boot;
  logic [8:0]            w_len_count;
  logic                  w_accept, w_reject;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_HUNT;
      r_remaining <= '0;
      r_sum       <= '0;
      r_ptr       <= '0;
      r_to_cnt    <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_cpu_rst   <= 1'b1;
      r_busy      <= 1'b0;
      r_ok        <= 1'b0;
      r_err       <= 1'b0;
      r_boot      <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_sum       <= w_sum_nxt;
      r_ptr       <= w_ptr_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_data  <= w_mem_data_nxt;
      r_cpu_rst   <= w_cpu_rst_nxt;
      r_busy      <= w_busy_nxt;
      r_ok        <= w_ok_nxt;
      r_err       <= w_err_nxt;
      r_boot      <= 1'b0;
    end
  end

  // LEN byte 0x00 encodes a full 256-byte image
  assign w_len_count = (r_shift == 8'h00) ? 9'd256 : {1'b0, r_shift};

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_sum_nxt       = r_sum;
    w_ptr_nxt       = r_ptr;
    w_to_cnt_nxt    = r_to_cnt;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_data_nxt  = r_mem_data;
    w_cpu_rst_nxt   = r_cpu_rst;
    w_busy_nxt      = r_busy;
    w_ok_nxt        = 1'b0;
    w_err_nxt       = 1'b0;
    w_accept        = 1'b0;
    w_reject        = 1'b0;

    if (r_boot && BOOT_RUN) begin
      w_cpu_rst_nxt = 1'b0;
    end

    if (r_state != ST_HUNT) begin
      w_to_cnt_nxt = w_rx_valid ? '0 : r_to_cnt + c_TO_ONE;
      if ((!w_rx_valid && r_to_cnt == c_TO_M1) || w_rx_ferr) begin
        w_reject = 1'b1;
      end
    end

    case (r_state)
      ST_HUNT: begin
        w_to_cnt_nxt = '0;
        if (w_rx_valid && r_shift == c_SYNC) begin
          w_state_nxt   = ST_LEN;
          w_busy_nxt    = 1'b1;
          w_cpu_rst_nxt = 1'b1;
          w_ptr_nxt     = '0;
        end
      end
      ST_LEN: begin
        if (w_rx_valid) begin
          w_remaining_nxt = w_len_count;
          w_sum_nxt       = '0;
          if (32'(w_len_count) > c_MAX_LEN) begin
            w_reject = 1'b1;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_rx_valid) begin
          w_mem_we_nxt    = 1'b1;
          w_mem_addr_nxt  = r_ptr;
          w_mem_data_nxt  = r_shift;
          w_ptr_nxt       = r_ptr + c_PTR_ONE;
          w_sum_nxt       = r_sum + r_shift;
          w_remaining_nxt = r_remaining - 9'd1;
          if (r_remaining == 9'd1) begin
            w_state_nxt = ST_SUM;
          end
        end
      end
      ST_SUM: begin
        if (w_rx_valid) begin
          if (r_shift == r_sum) w_accept = 1'b1;
          else                  w_reject = 1'b1;
        end
      end
      default: w_state_nxt = ST_HUNT;
    endcase

    if (w_accept) begin
      w_ok_nxt      = 1'b1;
      w_busy_nxt    = 1'b0;
      w_cpu_rst_nxt = 1'b0;
      w_state_nxt   = ST_HUNT;
    end
    if (w_reject) begin
      w_err_nxt     = 1'b1;
      w_busy_nxt    = 1'b0;
      w_cpu_rst_nxt = 1'b1;
      w_state_nxt   = ST_HUNT;
    end
  end

  assign MEM_WE   = r_mem_we;
  assign MEM_ADDR = r_mem_addr;
  assign MEM_DATA = r_mem_data;
  assign CPU_RST  = r_cpu_rst;
  assign BUSY     = r_busy;
  assign LOAD_OK  = r_ok;
  assign LOAD_ERR = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mc14500b_uart_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc14500b_uart_loader
//  Function : Directed bench for the UART program loader: frame table plus
//             hand-written noise, timeout, wrap and reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mc14500b_uart_loader;

  logic       CLK, RST, RX;
  logic       MEM_WE, CPU_RST, BUSY, LOAD_OK, LOAD_ERR;
  logic [7:0] MEM_ADDR, MEM_DATA;
  logic       h_we, h_cpu_rst, h_busy, h_ok, h_err;
  logic [7:0] h_addr, h_data;

  mc14500b_uart_loader #(
    .CLKS_PER_BIT(8), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(200), .BOOT_RUN(1'b1)
  ) dut (
    .CLK(CLK), .RST(RST), .RX(RX), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_DATA(MEM_DATA), .CPU_RST(CPU_RST), .BUSY(BUSY), .LOAD_OK(LOAD_OK),
    .LOAD_ERR(LOAD_ERR)
  );

  mc14500b_uart_loader #(
    .CLKS_PER_BIT(8), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(200), .BOOT_RUN(1'b0)
  ) dut_hold (
    .CLK(CLK), .RST(RST), .RX(RX), .MEM_WE(h_we), .MEM_ADDR(h_addr),
    .MEM_DATA(h_data), .CPU_RST(h_cpu_rst), .BUSY(h_busy), .LOAD_OK(h_ok),
    .LOAD_ERR(h_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         we_cnt, ok_cnt, err_cnt, we_cyc, err_cyc;
  logic [7:0] last_addr, last_data;
  logic       prev_busy = 1'b0;
  logic [7:0] mem [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // write/pulse monitor; also checks flag relationships at each event
  always @(negedge CLK) begin
    cyc++;
    if (MEM_WE) begin
      we_cnt++;
      mem[MEM_ADDR] = MEM_DATA;
      last_addr = MEM_ADDR;
      last_data = MEM_DATA;
      we_cyc = cyc;
      check("we_flags{busy,cpu_rst}", {30'd0, BUSY, CPU_RST}, 32'b11);
    end
    if (LOAD_OK) begin
      ok_cnt++;
      check("ok_flags{busy,cpu_rst,prev_busy}", {29'd0, BUSY, CPU_RST, prev_busy}, 32'b001);
    end
    if (LOAD_ERR) begin
      err_cnt++;
      err_cyc = cyc;
      check("err_flags{busy,cpu_rst,prev_busy}", {29'd0, BUSY, CPU_RST, prev_busy}, 32'b011);
    end
    prev_busy = BUSY;
  end

  task automatic clear_counts();
    we_cnt = 0; ok_cnt = 0; err_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      repeat (8) @(posedge CLK);
    end
    RX = 1'b1;
  endtask

  typedef struct {
    logic [0:7][7:0] b;
    int              n;
    int              we;
    int              ok;
    int              err;
    logic            cpu;
    logic [7:0]      addr;
    logic [7:0]      data;
  } vec_t;

  vec_t vecs [4];

  initial begin
    RX  = 1'b1;
    RST = 1'b1;

    vecs[0] = '{b: {8'hA5, 8'h03, 8'h12, 8'h34, 8'h56, 8'h9C, 8'h00, 8'h00},
                n: 6, we: 3, ok: 1, err: 0, cpu: 1'b0, addr: 8'd2, data: 8'h56};
    vecs[1] = '{b: {8'hA5, 8'h02, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00},
                n: 5, we: 2, ok: 0, err: 1, cpu: 1'b1, addr: 8'd1, data: 8'h02};
    vecs[2] = '{b: {8'h00, 8'hFF, 8'hA5, 8'h01, 8'hA5, 8'hA5, 8'h00, 8'h00},
                n: 6, we: 1, ok: 1, err: 0, cpu: 1'b0, addr: 8'd0, data: 8'hA5};
    vecs[3] = '{b: {8'hA5, 8'h02, 8'h10, 8'h20, 8'h30, 8'h00, 8'h00, 8'h00},
                n: 5, we: 2, ok: 1, err: 0, cpu: 1'b0, addr: 8'd1, data: 8'h20};

    idle(3);
    check("reset_outputs", {13'd0, MEM_WE, MEM_ADDR, MEM_DATA, CPU_RST, BUSY, LOAD_OK, LOAD_ERR},
          {13'd0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
    check("reset_hold_cpu_rst", {31'd0, h_cpu_rst}, 32'd1);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check("boot_run_release", {31'd0, CPU_RST}, 32'd0);
    check("boot_hold_cpu_rst", {31'd0, h_cpu_rst}, 32'd1);
    idle(10);
    check("hold_before_load", {31'd0, h_cpu_rst}, 32'd1);

    for (int i = 0; i < 4; i++) begin
      clear_counts();
      for (int k = 0; k < vecs[i].n; k++) send_byte(vecs[i].b[k], 1'b1);
      idle(30);
      check($sformatf("v%0d_writes", i), we_cnt, vecs[i].we);
      check($sformatf("v%0d_ok", i), ok_cnt, vecs[i].ok);
      check($sformatf("v%0d_err", i), err_cnt, vecs[i].err);
      check($sformatf("v%0d_cpu_rst", i), {31'd0, CPU_RST}, {31'd0, vecs[i].cpu});
      check($sformatf("v%0d_busy", i), {31'd0, BUSY}, 32'd0);
      check($sformatf("v%0d_last_addr", i), {24'd0, last_addr}, {24'd0, vecs[i].addr});
      check($sformatf("v%0d_last_data", i), {24'd0, last_data}, {24'd0, vecs[i].data});
      if (i == 0) begin
        check("v0_mem0", {24'd0, mem[0]}, 32'h12);
        check("v0_mem1", {24'd0, mem[1]}, 32'h34);
        check("v0_mem2", {24'd0, mem[2]}, 32'h56);
      end
    end
    check("hold_after_load", {31'd0, h_cpu_rst}, 32'd0);

    // leading junk and a short low glitch ahead of a good frame
    clear_counts();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(5);
    RX = 1'b0;
    repeat (3) @(posedge CLK);
    RX = 1'b1;
    idle(20);
    send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'hAA, 1'b1); send_byte(8'h55, 1'b1); send_byte(8'hFF, 1'b1);
    idle(30);
    check("glitch_ok", ok_cnt, 1);
    check("glitch_err", err_cnt, 0);
    check("glitch_mem0", {24'd0, mem[0]}, 32'hAA);
    check("glitch_mem1", {24'd0, mem[1]}, 32'h55);

    // low stop bit while in DATA
    clear_counts();
    send_byte(8'hA5, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    idle(30);
    check("ferr_err", err_cnt, 1);
    check("ferr_ok", ok_cnt, 0);
    check("ferr_writes", we_cnt, 1);
    check("ferr_cpu_rst", {31'd0, CPU_RST}, 32'd1);

    // inter-byte timeout, then recovery
    clear_counts();
    send_byte(8'hA5, 1'b1); send_byte(8'h04, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    idle(300);
    check("to_err", err_cnt, 1);
    check("to_writes", we_cnt, 2);
    check("to_latency_in_195_205",
          {31'd0, ((err_cyc - we_cyc) >= 195) && ((err_cyc - we_cyc) <= 205)}, 32'd1);
    check("to_busy", {31'd0, BUSY}, 32'd0);
    clear_counts();
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h07, 1'b1); send_byte(8'h07, 1'b1);
    idle(30);
    check("to_recover_ok", ok_cnt, 1);

    // LEN=0 means 256 bytes; address wraps after the top location
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    clear_counts();
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1);
    for (int k = 0; k < 256; k++) send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    idle(30);
    begin
      int ones;
      ones = 0;
      for (int a = 0; a < 256; a++) if (mem[a] == 8'h01) ones++;
      check("len256_all_addrs_written", ones, 256);
    end
    check("len256_writes", we_cnt, 256);
    check("len256_ok", ok_cnt, 1);
    check("len256_last_addr", {24'd0, last_addr}, 32'd255);

    // reset in the middle of DATA
    clear_counts();
    send_byte(8'hA5, 1'b1); send_byte(8'h04, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    idle(3);
    #2 RST = 1'b1;
    #1;
    check("midrst_outputs", {13'd0, MEM_WE, MEM_ADDR, MEM_DATA, CPU_RST, BUSY, LOAD_OK, LOAD_ERR},
          {13'd0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
    idle(2);
    RST = 1'b0;
    idle(20);
    check("midrst_no_err", err_cnt, 0);
    clear_counts();
    send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1);
    idle(30);
    check("midrst_next_ok", ok_cnt, 1);
    check("midrst_next_err", err_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
